// File: rtl/tw_factor_loader.sv
// Runtime-loadable twiddle-factor table for the SDF-64 NTT: range-checked valid/ready load
// stream in, whole table out on the flattened psi bus the NTT stages consume.
module tw_factor_loader #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 64,
   parameter int MODULUS    = 7681
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   load_start_i,
   input  logic                                   in_valid_i,
   output logic                                   in_ready_o,
   input  logic [DATA_WIDTH-1:0]                  in_data_i,
   output logic [ADDR_WIDTH-1:0]                  wr_count_o,
   output logic                                   load_busy_o,
   output logic                                   table_valid_o,
   output logic                                   range_err_o,
   output logic [DATA_WIDTH*((1<<ADDR_WIDTH)-1)-1:0] psi_out_o
);

   localparam int                    N     = (1 << ADDR_WIDTH) - 1;
   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(N - 1);
   localparam logic [DATA_WIDTH-1:0] MOD_W = DATA_WIDTH'(MODULUS);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                               state_q, state_d;
   logic [ADDR_WIDTH-1:0]                wr_count_q, wr_count_d;
   logic                                 table_valid_q, table_valid_d;
   logic                                 range_err_q, range_err_d;
   logic [N-1:0][DATA_WIDTH-1:0]         tbl_q;

   logic accept, legal, wr_en, last_beat;

   assign accept    = in_valid_i && in_ready_o;
   assign legal     = in_data_i < MOD_W;
   // load_start wins over a beat handshaken in the same cycle
   assign wr_en     = accept && legal && !load_start_i;
   assign last_beat = wr_en && (wr_count_q == LAST);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (load_start_i) state_d = LOAD;
         LOAD:    if (load_start_i) state_d = LOAD;
                  else if (last_beat) state_d = DONE;
         DONE:    if (load_start_i) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready_o  = (state_q == LOAD);
      load_busy_o = (state_q == LOAD);
   end

   always_comb begin
      wr_count_d    = wr_count_q;
      table_valid_d = table_valid_q;
      range_err_d   = range_err_q;
      if (load_start_i) begin
         wr_count_d    = '0;
         table_valid_d = 1'b0;
         range_err_d   = 1'b0;
      end else if (accept) begin
         if (!legal) begin
            range_err_d = 1'b1;
         end else if (last_beat) begin
            wr_count_d    = '0;
            table_valid_d = 1'b1;
         end else begin
            wr_count_d = wr_count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_count_q    <= '0;
         table_valid_q <= 1'b0;
         range_err_q   <= 1'b0;
      end else begin
         wr_count_q    <= wr_count_d;
         table_valid_q <= table_valid_d;
         range_err_q   <= range_err_d;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tbl_q <= '0;
      end else begin
         for (int i = 0; i < N; i++)
            if (wr_en && (wr_count_q == ADDR_WIDTH'(i))) tbl_q[i] <= in_data_i;
      end
   end

   assign wr_count_o    = wr_count_q;
   assign table_valid_o = table_valid_q;
   assign range_err_o   = range_err_q;
   assign psi_out_o     = tbl_q;

endmodule

// File: tb/tb_tw_factor_loader.sv
// Directed bench for tw_factor_loader: reset, full loads (dense and gapped), range errors,
// restart mid-load, partial reload from DONE and async reset.
module tb_tw_factor_loader;

   localparam int N = 63;

   logic                clk = 1'b0;
   logic                clk_en = 1'b0;
   logic                rst = 1'b0;
   logic                load_start = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [63:0]         in_data = '0;
   logic [5:0]          wr_count;
   logic                load_busy, table_valid, range_err;
   logic [64*N-1:0]     psi_out;

   logic [N-1:0][63:0]  exp_tbl;
   int                  n_cmp = 0;
   int                  n_err = 0;

   always #5 if (clk_en) clk = ~clk;

   tw_factor_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(64), .MODULUS(7681)) dut (
      .clk_i(clk), .rst_i(rst), .load_start_i(load_start), .in_valid_i(in_valid),
      .in_ready_o(in_ready), .in_data_i(in_data), .wr_count_o(wr_count),
      .load_busy_o(load_busy), .table_valid_o(table_valid), .range_err_o(range_err),
      .psi_out_o(psi_out)
   );

   function automatic logic [63:0] val(input int i);
      if (i == 0)  return 64'h0AA4;
      if (i == 1)  return 64'h014A;
      if (i == 62) return 64'h1284;
      return 64'((i * 97 + 13) % 7681);
   endfunction

   function automatic logic [63:0] alt(input int i);
      return 64'(7000 - i * 11);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tbl(input string tag);
      n_cmp++;
      assert (psi_out === exp_tbl) else begin
         n_err++;
         for (int s = 0; s < N; s++)
            if (psi_out[64*s +: 64] !== exp_tbl[s]) begin
               $error("FAIL %s: slot %0d observed %0h expected %0h", tag, s,
                      psi_out[64*s +: 64], exp_tbl[s]);
               break;
            end
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1; tick(); load_start = 1'b0;
   endtask

   task automatic beat(input logic [63:0] d);
      in_valid = 1'b1; in_data = d; tick(); in_valid = 1'b0; in_data = '0;
   endtask

   initial begin
      int i, cyc, ecnt;

      // 1: reset with clock stopped
      #1 rst = 1'b1;
      #1;
      exp_tbl = '0;
      chk_tbl("rst_psi");
      chk("rst_in_ready", in_ready, 0);
      chk("rst_table_valid", table_valid, 0);
      chk("rst_range_err", range_err, 0);
      chk("rst_wr_count", wr_count, 0);
      chk("rst_load_busy", load_busy, 0);
      clk_en = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();

      // 2: dense load of 63 factors; in_valid in IDLE is ignored
      beat(64'h0005);
      chk("idle_ignore_wr", wr_count, 0);
      pulse_start();
      chk("t2_busy", load_busy, 1);
      chk("t2_ready", in_ready, 1);
      for (int k = 0; k < N; k++) begin
         beat(val(k));
         exp_tbl[k] = val(k);
         if (k == 30) chk("t2_mid_wr", wr_count, 31);
      end
      chk("t2_table_valid", table_valid, 1);
      chk("t2_ready_after", in_ready, 0);
      chk("t2_wr_after", wr_count, 0);
      chk("t2_slot0", psi_out[63:0], 64'h0AA4);
      chk("t2_slot62", psi_out[4031:3968], 64'h1284);
      chk_tbl("t2_tbl");
      beat(64'h0001);
      chk_tbl("t2_done_ignore");

      // 3: same table with random valid gaps; illegal data on idle cycles must be ignored
      pulse_start();
      chk("t3_tv_fall", table_valid, 0);
      i = 0; cyc = 0;
      while (i < N && cyc < 2000) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data  = in_valid ? val(i) : 64'hFFFF_FFFF_FFFF_FFFF;
         tick();
         if (in_valid) i++;
         cyc++;
         ecnt = (i == N) ? 0 : i;
         chk("t3_wr_step", wr_count, 64'(ecnt));
      end
      in_valid = 1'b0; in_data = '0;
      chk("t3_done", 64'(i), 64'(N));
      chk("t3_table_valid", table_valid, 1);
      chk("t3_range_err", range_err, 0);
      chk_tbl("t3_tbl");

      // 4: range errors and the legal boundary
      pulse_start();
      for (int k = 0; k < 5; k++) begin
         beat(alt(k));
         exp_tbl[k] = alt(k);
      end
      chk("t4_wr5", wr_count, 5);
      beat(64'h1E01);
      chk("t4_err", range_err, 1);
      chk("t4_wr_hold", wr_count, 5);
      chk("t4_slot5_keep", psi_out[64*5 +: 64], val(5));
      beat(64'h14A2);
      exp_tbl[5] = 64'h14A2;
      chk("t4_slot5_new", psi_out[64*5 +: 64], 64'h14A2);
      chk("t4_wr6", wr_count, 6);
      chk("t4_err_sticky", range_err, 1);
      beat(64'h1E00);
      exp_tbl[6] = 64'h1E00;
      chk("t4_slot6_max", psi_out[64*6 +: 64], 64'h1E00);
      beat(64'h8000_0000_0000_0001);
      chk("t4_wr_hi_bit", wr_count, 7);
      chk_tbl("t4_tbl");

      // 5: restart while a beat is handshaken
      for (int k = 7; k < 20; k++) begin
         beat(alt(k));
         exp_tbl[k] = alt(k);
      end
      chk("t5_wr20", wr_count, 20);
      load_start = 1'b1; in_valid = 1'b1; in_data = 64'h0123;
      tick();
      load_start = 1'b0; in_valid = 1'b0;
      chk("t5_wr0", wr_count, 0);
      chk("t5_err_clr", range_err, 0);
      chk("t5_slot20_keep", psi_out[64*20 +: 64], val(20));
      beat(64'h0777);
      exp_tbl[0] = 64'h0777;
      chk("t5_slot0", psi_out[63:0], 64'h0777);
      chk("t5_wr1", wr_count, 1);
      for (int k = 1; k < N; k++) begin
         beat(val(k));
         exp_tbl[k] = val(k);
      end
      chk("t5_table_valid", table_valid, 1);
      chk_tbl("t5_tbl");

      // 6: partial reload from DONE, then async reset mid-load
      pulse_start();
      chk("t6_tv_fall", table_valid, 0);
      for (int k = 0; k < 10; k++) begin
         beat(64'h1000 + 64'(k));
         exp_tbl[k] = 64'h1000 + 64'(k);
      end
      chk("t6_wr10", wr_count, 10);
      chk_tbl("t6_partial");
      #2 rst = 1'b1;
      #1;
      exp_tbl = '0;
      chk_tbl("t6_rst_psi");
      chk("t6_rst_ready", in_ready, 0);
      chk("t6_rst_wr", wr_count, 0);
      chk("t6_rst_busy", load_busy, 0);
      tick();
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
